imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Byte-stream program loader: the writer side of the instruction memory.
//   - Receives a framed byte stream (e.g. from a UART receiver).
//   - Assembles little-endian 32-bit words and writes them into imem.
//   - Holds the core in reset until a frame completes with a valid checksum.
//   - Sits between the serial receiver and the imem write port / core reset.
// PARAMETERS
//   DEPTH      64     imem capacity in 32-bit words; larger frames are rejected
//   BASE_ADDR  32'h0  byte address of the first word written
//   SYNC       8'hA5  frame header byte
// PORTS
//   clk        in   1   clock
//   reset      in   1   asynchronous, active-high reset
//   start      in   1   one-cycle request to begin or restart a load
//   rx_valid   in   1   rx_data holds a byte
//   rx_data    in   8   received byte
//   rx_ready   out  1   loader accepts a byte this cycle
//   mem_we     out  1   imem write strobe, one-cycle pulse
//   mem_addr   out  32  imem byte address (word aligned)
//   mem_wdata  out  32  imem write data
//   core_reset out  1   reset to the core; high while not loaded
//   done       out  1   frame loaded and checksum ok (level)
//   error      out  1   frame rejected (level)
// BEHAVIOUR
//   Reset is asynchronous and active-high on clk; clock is clk.
//   Reset values: state=IDLE, rx_ready=0, mem_we=0, mem_addr=BASE_ADDR,
//     mem_wdata=0, core_reset=1, done=0, error=0, counters and checksum=0.
//   Byte transfer: a byte moves when rx_valid & rx_ready are both high on a
//     posedge. rx_ready is high only in HDR, LEN0, LEN1, DATA and CSUM.
//   Frame format: SYNC, N[7:0], N[15:8], N*4 data bytes (LSB first), CSUM.
//     CSUM is the XOR of both length bytes and all data bytes.
//   FSM transitions:
//     IDLE: start -> HDR (clear checksum, word index, done, error).
//     HDR:  byte==SYNC -> LEN0; any other byte is discarded, stay in HDR.
//     LEN0: latch N low byte -> LEN1.
//     LEN1: latch N high byte.
//           N > DEPTH -> ERR; N==0 -> CSUM; otherwise -> DATA.
//     DATA: shift bytes into a separate assembly register.
//           On the 4th byte, the next cycle gives:
//             mem_we=1, mem_wdata={b3,b2,b1,b0}, mem_addr=BASE_ADDR+4*idx.
//           idx then increments. After word N-1 -> CSUM.
//           A byte may be accepted in the same cycle as mem_we (no bubble).
//     CSUM: byte==running XOR -> DONE; mismatch -> ERR.
//     DONE: done=1, core_reset=0. start -> HDR with core_reset=1, done=0.
//     ERR:  error=1, core_reset=1. start -> HDR with error=0.
//   Other rules:
//     - start is ignored in HDR..CSUM.
//     - start has priority over rx_valid on entry to HDR; no byte is accepted
//       in IDLE.
//     - core_reset deasserts only in DONE, registered, one cycle after the
//       checksum byte is accepted.
//     - Words written before an ERR remain in imem and are not rolled back.
//     - mem_addr and mem_wdata hold their last values between strobes.
//     - idx is 16 bits wide and does not wrap, because N <= DEPTH is enforced.
//     - Reset mid-frame aborts immediately to the reset state.
//     - rx_valid gaps of any length are tolerated in every receive state.
// TESTING
//   1. 2-word load:
//        start, A5 02 00 13 01 50 00 93 01 C0 00 12
//        -> writes 0x00500113@0x0 and 0x00C00193@0x4
//        -> done=1, core_reset=0
//   2. Empty frame: A5 00 00 00 -> no mem_we, done=1.
//   3. Bad checksum: A5 01 00 13 01 50 00 44 (expected 43)
//        -> one write@0x0, error=1, core_reset=1, done=0.
//   4. Oversize: A5 41 00 with DEPTH=64 -> error=1 right after LEN1, no mem_we.
//   5. Garbage and gaps: 00 FF then frame 3 with CSUM 43, random rx_valid gaps
//        -> garbage ignored, single write 0x00500113@0x0, done=1.
//   6. Reset mid-DATA after 2 data bytes -> all outputs return to reset values.
//        A following start plus frame 1 completes normally.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream receive handshake and imem write port shared by the program loader.
// The master side is the serial source / memory observer; the slave side is the loader.
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: parses SYNC/length/data/checksum frames, writes little-endian words
// into imem and releases the core reset only after a frame checks out.
module imem_loader #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [7:0]  SYNC      = 8'hA5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          core_reset,
  output logic          done,
  output logic          error
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HDR  = 3'd1;
  localparam logic [2:0] LEN0 = 3'd2;
  localparam logic [2:0] LEN1 = 3'd3;
  localparam logic [2:0] DATA = 3'd4;
  localparam logic [2:0] CSUM = 3'd5;
  localparam logic [2:0] DONE = 3'd6;
  localparam logic [2:0] ERR  = 3'd7;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  logic [2:0]  state;
  logic [15:0] len;
  logic [15:0] idx;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_reg;
  logic [7:0]  csum;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        rx_ready_c;
  logic        accept;
  logic [15:0] len_next;

  assign rx_ready_c = (state == HDR) || (state == LEN0) || (state == LEN1) ||
                      (state == DATA) || (state == CSUM);
  assign accept     = bus.rx_valid & rx_ready_c;
  assign len_next   = {bus.rx_data, len[7:0]};

  assign bus.rx_ready  = rx_ready_c;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Frame parser; the first three data bytes of a word are buffered, the fourth
  // completes the word and schedules the write strobe for the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      len         <= 16'd0;
      idx         <= 16'd0;
      byte_cnt    <= 2'd0;
      asm_reg     <= 24'd0;
      csum        <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= 32'd0;
      core_reset  <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= HDR;
            csum     <= 8'd0;
            idx      <= 16'd0;
            byte_cnt <= 2'd0;
            done     <= 1'b0;
            error    <= 1'b0;
          end
        end
        HDR: begin
          if (accept && (bus.rx_data == SYNC)) begin
            state <= LEN0;
          end
        end
        LEN0: begin
          if (accept) begin
            len[7:0] <= bus.rx_data;
            csum     <= csum ^ bus.rx_data;
            state    <= LEN1;
          end
        end
        LEN1: begin
          if (accept) begin
            len[15:8] <= bus.rx_data;
            csum      <= csum ^ bus.rx_data;
            if ({1'b0, len_next} > DEPTH_W) begin
              state <= ERR;
              error <= 1'b1;
            end else if (len_next == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            csum     <= csum ^ bus.rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem_we_q    <= 1'b1;
              mem_wdata_q <= {bus.rx_data, asm_reg};
              mem_addr_q  <= BASE_ADDR + {14'd0, idx, 2'b00};
              idx         <= idx + 16'd1;
              if (idx == len - 16'd1) begin
                state <= CSUM;
              end
            end else begin
              asm_reg <= {bus.rx_data, asm_reg[23:8]};
            end
          end
        end
        CSUM: begin
          if (accept) begin
            if (bus.rx_data == csum) begin
              state      <= DONE;
              done       <= 1'b1;
              core_reset <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            state      <= HDR;
            core_reset <= 1'b1;
            done       <= 1'b0;
            csum       <= 8'd0;
            idx        <= 16'd0;
            byte_cnt   <= 2'd0;
          end
        end
        ERR: begin
          if (start) begin
            state    <= HDR;
            error    <= 1'b0;
            csum     <= 8'd0;
            idx      <= 16'd0;
            byte_cnt <= 2'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames are streamed in, expected imem writes
// are queued up front and matched against every mem_we strobe.
module tb_imem_loader;

  logic clk;
  logic reset;
  logic start;
  logic core_reset;
  logic done;
  logic error;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(64), .BASE_ADDR(32'h0), .SYNC(8'hA5)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [7:0]  tx_bytes[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every write strobe is matched against the next queued {addr, data} expectation.
  always @(negedge clk) begin
    if (!reset && bus.mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: got addr=%h data=%h, required no write", bus.mem_addr, bus.mem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== e) begin
          errors++;
          $display("[TB] FAIL mem_write: got addr=%h data=%h, required addr=%h data=%h",
                   bus.mem_addr, bus.mem_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int waited;
    if (gaps) begin
      bus.rx_valid = 1'b0;
      repeat (int'($urandom_range(0, 3))) @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    waited = 0;
    while (!bus.rx_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.rx_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL rx_ready_timeout: byte %h not accepted, required acceptance within 200 cycles", b);
    end else begin
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gaps);
    foreach (tx_bytes[i]) send_byte(tx_bytes[i], gaps);
  endtask

  task automatic check_status(input string name, input logic [2:0] exp);
    checks++;
    if ({core_reset, done, error} !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got core_reset/done/error=%b, required %b", name, {core_reset, done, error}, exp);
    end
  endtask

  task automatic drain_and_check(input string name);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_writes: got %0d writes missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (bus.rx_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_rx_ready: got %b, required 0", name, bus.rx_ready);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (bus.rx_ready !== 1'b0 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_handshake: got rx_ready=%b mem_we=%b, required 0 0", bus.rx_ready, bus.mem_we);
    end
    checks++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_mem: got addr=%h data=%h, required 0 0", bus.mem_addr, bus.mem_wdata);
    end
    check_status("reset_status", 3'b100);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.rx_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_rx_ready: got %b, required 0", bus.rx_ready);
    end
  endtask

  task automatic test_two_word();
    exp_q.push_back({32'h0, 32'h00500113});
    exp_q.push_back({32'h4, 32'h00C00193});
    pulse_start();
    tx_bytes = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00,
                 8'h93, 8'h01, 8'hC0, 8'h00, 8'h12};
    send_frame(1'b0);
    check_status("two_word_status", 3'b010);
    drain_and_check("two_word");
    checks++;
    if (bus.mem_addr !== 32'h4 || bus.mem_wdata !== 32'h00C00193) begin
      errors++;
      $display("[TB] FAIL two_word_hold: got addr=%h data=%h, required 00000004 00c00193", bus.mem_addr, bus.mem_wdata);
    end
  endtask

  task automatic test_empty();
    pulse_start();
    check_status("restart_status", 3'b100);
    tx_bytes = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(1'b0);
    check_status("empty_status", 3'b010);
    drain_and_check("empty");
  endtask

  task automatic test_bad_csum();
    exp_q.push_back({32'h0, 32'h00500113});
    pulse_start();
    tx_bytes = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h44};
    send_frame(1'b0);
    check_status("bad_csum_status", 3'b101);
    drain_and_check("bad_csum");
  endtask

  task automatic test_oversize();
    pulse_start();
    check_status("err_clear_status", 3'b100);
    tx_bytes = '{8'hA5, 8'h41, 8'h00};
    send_frame(1'b0);
    check_status("oversize_status", 3'b101);
    drain_and_check("oversize");
  endtask

  task automatic test_full_depth();
    logic [7:0]  cs;
    logic [31:0] w;
    cs = 8'h40;
    tx_bytes = '{8'hA5, 8'h40, 8'h00};
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      exp_q.push_back({32'(i * 4), w});
      for (int k = 0; k < 4; k++) begin
        tx_bytes.push_back(w[k*8 +: 8]);
        cs = cs ^ w[k*8 +: 8];
      end
    end
    tx_bytes.push_back(cs);
    pulse_start();
    send_frame(1'b0);
    check_status("full_depth_status", 3'b010);
    drain_and_check("full_depth");
  endtask

  task automatic test_garbage_gaps();
    exp_q.push_back({32'h0, 32'h00500113});
    pulse_start();
    tx_bytes = '{8'h00, 8'hFF};
    send_frame(1'b1);
    pulse_start();
    tx_bytes = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h43};
    send_frame(1'b1);
    check_status("garbage_status", 3'b010);
    drain_and_check("garbage");
  endtask

  task automatic test_reset_mid_data();
    pulse_start();
    tx_bytes = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h01};
    send_frame(1'b0);
    reset = 1'b1;
    #2;
    checks++;
    if (bus.rx_ready !== 1'b0 || bus.mem_we !== 1'b0 ||
        bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset_bus: got rx_ready=%b we=%b addr=%h data=%h, required 0 0 0 0",
               bus.rx_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    check_status("mid_reset_status", 3'b100);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.push_back({32'h0, 32'h00500113});
    exp_q.push_back({32'h4, 32'h00C00193});
    pulse_start();
    tx_bytes = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00,
                 8'h93, 8'h01, 8'hC0, 8'h00, 8'h12};
    send_frame(1'b1);
    check_status("after_reset_status", 3'b010);
    drain_and_check("after_reset");
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_two_word();
    test_empty();
    test_bad_csum();
    test_oversize();
    test_full_depth();
    test_garbage_gaps();
    test_reset_mid_data();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
